// File: rtl/wmem_arbiter.sv
// wmem_arbiter: shares one single-port weight/bias memory among NUM_REQ layer engines, one burst at a time.
// Define WMEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module wmem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 512,
  parameter int LEN_W   = 11,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      mem_ren,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [ID_W-1:0]    id_r;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win;
  logic [NUM_REQ-1:0] win_oh;
  logic [ADDR_W-1:0]  win_base;
  logic [ADDR_W-1:0]  base_r;
  logic [LEN_W-1:0]   win_len;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   cnt;
  logic               inflight;
  logic [NUM_REQ-1:0] vld_p [RD_LAT];

  // First set request bit at or above ptr, wrapping; ptr stays 0 in the fixed-priority build.
  function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                  input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && r[idx]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    win         = pick_winner(req, rr_ptr);
    win_oh      = '0;
    win_oh[win] = 1'b1;
    win_base    = req_base[win*ADDR_W +: ADDR_W];
    win_len     = req_len[win*LEN_W +: LEN_W];
    // Reads still to arrive after this edge; the last stage is being delivered now.
    inflight = mem_ren;
    for (int k = 0; k < RD_LAT-1; k++) inflight = inflight | (|vld_p[k]);
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && |req) begin
      base_r <= win_base;
      len_r  <= win_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      done     <= '0;
      mem_ren  <= 1'b0;
      mem_addr <= '0;
      rr_ptr   <= '0;
      id_r     <= '0;
      cnt      <= '0;
      for (int k = 0; k < RD_LAT; k++) vld_p[k] <= '0;
    end else begin
      // Read-return pipeline: one-hot requester tag follows each issued read for RD_LAT cycles.
      vld_p[0] <= mem_ren ? gnt : '0;
      for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];

      case (state)
        S_IDLE: begin
          if (|req) begin
            id_r <= win;
            gnt  <= win_oh;
            if (win_len != '0) begin
              state    <= S_ISSUE;
              mem_ren  <= 1'b1;
              mem_addr <= win_base;
              cnt      <= LEN_W'(1);
            end else begin
              state <= S_DONE;
              done  <= win_oh;
              cnt   <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (cnt == len_r || !req[id_r]) begin
            state   <= S_DRAIN;
            mem_ren <= 1'b0;
          end else begin
            mem_addr <= base_r + ADDR_W'(cnt);
            cnt      <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!inflight) begin
            state <= S_DONE;
            done  <= gnt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          done  <= '0;
`ifdef WMEM_ARB_FIXED_PRIO_EN
          rr_ptr <= '0;
`else
          rr_ptr <= (id_r == ID_W'(NUM_REQ-1)) ? '0 : id_r + 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid = vld_p[RD_LAT-1];
  assign rd_data  = mem_rdata;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_wmem_arbiter.sv
// Self-checking bench for wmem_arbiter: vector table, hand-written corner sequences and a
// randomized phase against a burst-schedule reference model.
module tb_wmem_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 512;
  localparam int LEN_W   = 11;
  localparam int RD_LAT  = 2;
  localparam int OW      = 3*NUM_REQ + ADDR_W + 2;
  localparam int NR      = 1500;
  localparam int NV      = 20;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_base;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      mem_ren;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;

  logic [ADDR_W-1:0] eng_base [NUM_REQ];
  logic [LEN_W-1:0]  eng_len  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_base[g*ADDR_W +: ADDR_W] = eng_base[g];
    assign req_len[g*LEN_W +: LEN_W]    = eng_len[g];
  end

  wmem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
    .gnt(gnt), .done(done), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NUM_REQ-1:0] req;
    int                 eng;
    logic [ADDR_W-1:0]  base;
    logic [LEN_W-1:0]   len;
    logic [NUM_REQ-1:0] e_gnt;
    logic [NUM_REQ-1:0] e_done;
    logic               e_ren;
    logic [ADDR_W-1:0]  e_addr;
    logic [NUM_REQ-1:0] e_rdv;
  } vec_t;

  vec_t tbl [NV];

  // Reference schedule for the randomized phase, indexed by cycle.
  logic [NUM_REQ-1:0] x_gnt  [NR+16];
  logic [NUM_REQ-1:0] x_done [NR+16];
  logic [NUM_REQ-1:0] x_rdv  [NR+16];
  logic               x_ren  [NR+16];
  logic [ADDR_W-1:0]  x_addr [NR+16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] obs(input logic use_addr);
    return {gnt, done, mem_ren, (use_addr ? mem_addr : {ADDR_W{1'b0}}), rd_valid, busy};
  endfunction

  function automatic logic [OW-1:0] expv(input logic [NUM_REQ-1:0] g, input logic [NUM_REQ-1:0] d,
                                         input logic r, input logic [ADDR_W-1:0] a,
                                         input logic [NUM_REQ-1:0] v);
    return {g, d, r, (r ? a : {ADDR_W{1'b0}}), v, |g};
  endfunction

  function automatic vec_t mk(input logic [NUM_REQ-1:0] rq, input int eng, input logic [ADDR_W-1:0] b,
                              input logic [LEN_W-1:0] l, input logic [NUM_REQ-1:0] g,
                              input logic [NUM_REQ-1:0] d, input logic r,
                              input logic [ADDR_W-1:0] a, input logic [NUM_REQ-1:0] v);
    vec_t t;
    t.req = rq; t.eng = eng; t.base = b; t.len = l;
    t.e_gnt = g; t.e_done = d; t.e_ren = r; t.e_addr = a; t.e_rdv = v;
    return t;
  endfunction

  // Request selection rule of the arbiter, stated directly.
  function automatic int pick(input logic [NUM_REQ-1:0] r, input int ptr);
    int p;
    p = ptr;
`ifdef WMEM_ARB_FIXED_PRIO_EN
    p = 0;
`endif
    for (int i = 0; i < NUM_REQ; i++)
      if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n_ren, n_rdv, n_done, done_c, quiet, m_free, m_ptr, w, len_i;
    logic [NUM_REQ-1:0] oh, order, eg, ed;
    logic [ADDR_W-1:0]  b;

    rst = 1'b1;
    req = '0;
    mem_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eng_base[i] = '0;
      eng_len[i]  = '0;
    end

    // Single burst, then zero-length burst, then address-wrapping burst.
    tbl[0]  = mk(3'b001, 0, 10'h010, 11'd4, 3'b000, 3'b000, 1'b0, 10'h000, 3'b000);
    tbl[1]  = mk(3'b001, -1, 10'h000, 11'd0, 3'b001, 3'b000, 1'b1, 10'h010, 3'b000);
    tbl[2]  = mk(3'b001, -1, 10'h000, 11'd0, 3'b001, 3'b000, 1'b1, 10'h011, 3'b000);
    tbl[3]  = mk(3'b001, -1, 10'h000, 11'd0, 3'b001, 3'b000, 1'b1, 10'h012, 3'b001);
    tbl[4]  = mk(3'b001, -1, 10'h000, 11'd0, 3'b001, 3'b000, 1'b1, 10'h013, 3'b001);
    tbl[5]  = mk(3'b001, -1, 10'h000, 11'd0, 3'b001, 3'b000, 1'b0, 10'h000, 3'b001);
    tbl[6]  = mk(3'b001, -1, 10'h000, 11'd0, 3'b001, 3'b000, 1'b0, 10'h000, 3'b001);
    tbl[7]  = mk(3'b000, -1, 10'h000, 11'd0, 3'b001, 3'b001, 1'b0, 10'h000, 3'b000);
    tbl[8]  = mk(3'b000, -1, 10'h000, 11'd0, 3'b000, 3'b000, 1'b0, 10'h000, 3'b000);
    tbl[9]  = mk(3'b010, 1, 10'h000, 11'd0, 3'b000, 3'b000, 1'b0, 10'h000, 3'b000);
    tbl[10] = mk(3'b000, -1, 10'h000, 11'd0, 3'b010, 3'b010, 1'b0, 10'h000, 3'b000);
    tbl[11] = mk(3'b100, 2, 10'h3FE, 11'd4, 3'b000, 3'b000, 1'b0, 10'h000, 3'b000);
    tbl[12] = mk(3'b100, -1, 10'h000, 11'd0, 3'b100, 3'b000, 1'b1, 10'h3FE, 3'b000);
    tbl[13] = mk(3'b100, -1, 10'h000, 11'd0, 3'b100, 3'b000, 1'b1, 10'h3FF, 3'b000);
    tbl[14] = mk(3'b100, -1, 10'h000, 11'd0, 3'b100, 3'b000, 1'b1, 10'h000, 3'b100);
    tbl[15] = mk(3'b100, -1, 10'h000, 11'd0, 3'b100, 3'b000, 1'b1, 10'h001, 3'b100);
    tbl[16] = mk(3'b100, -1, 10'h000, 11'd0, 3'b100, 3'b000, 1'b0, 10'h000, 3'b100);
    tbl[17] = mk(3'b100, -1, 10'h000, 11'd0, 3'b100, 3'b000, 1'b0, 10'h000, 3'b100);
    tbl[18] = mk(3'b000, -1, 10'h000, 11'd0, 3'b100, 3'b100, 1'b0, 10'h000, 3'b000);
    tbl[19] = mk(3'b000, -1, 10'h000, 11'd0, 3'b000, 3'b000, 1'b0, 10'h000, 3'b000);

    do_reset();
    chk("reset_state", obs(1'b1), OW'(0));

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("vec%0d", i), obs(tbl[i].e_ren),
          expv(tbl[i].e_gnt, tbl[i].e_done, tbl[i].e_ren, tbl[i].e_addr, tbl[i].e_rdv));
      req = tbl[i].req;
      if (tbl[i].eng >= 0) begin
        eng_base[tbl[i].eng] = tbl[i].base;
        eng_len[tbl[i].eng]  = tbl[i].len;
      end
      tick();
    end

    // All engines requesting len=2 continuously: 6-cycle burst period incl. one idle cycle.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      eng_base[i] = ADDR_W'(i * 256);
      eng_len[i]  = LEN_W'(2);
    end
    req = '1;
    for (int c = 0; c < 25; c++) begin
`ifdef WMEM_ARB_FIXED_PRIO_EN
      order = NUM_REQ'(1);
`else
      order = NUM_REQ'(1) << ((c / 6) % NUM_REQ);
`endif
      eg = (c % 6 == 0) ? '0 : order;
      ed = (c % 6 == 5) ? order : '0;
      chk($sformatf("rr_c%0d", c), OW'({gnt, done}), OW'({eg, ed}));
      tick();
    end

    // Abort: requester 0 drops req in the third ISSUE cycle of a len=8 burst.
    do_reset();
    eng_base[0] = 10'h040;
    eng_len[0]  = 11'd8;
    req = 3'b001;
    n_ren = 0; n_rdv = 0; n_done = 0; done_c = -1;
    for (int c = 0; c < 12; c++) begin
      if (mem_ren) begin
        b = 10'h040 + ADDR_W'(n_ren);
        chk($sformatf("abort_addr%0d", n_ren), OW'(mem_addr), OW'(b));
        n_ren++;
      end
      if (rd_valid == 3'b001) n_rdv++;
      if (done == 3'b001) begin
        n_done++;
        done_c = c;
      end
      if (c == 3) req = '0;
      tick();
    end
    chk_int("abort_ren_count", n_ren, 3);
    chk_int("abort_rdv_count", n_rdv, 3);
    chk_int("abort_done_count", n_done, 1);
    chk_int("abort_done_cycle", done_c, 3 + RD_LAT + 1);

    // Reset asserted during DRAIN while reads are still in flight.
    do_reset();
    eng_base[0] = 10'h100;
    eng_len[0]  = 11'd6;
    req = 3'b001;
    for (int c = 0; c < 7; c++) tick();
    chk("drain_before_rst", obs(1'b0), expv(3'b001, 3'b000, 1'b0, 10'h000, 3'b001));
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    chk("rst_mid_burst", obs(1'b1), OW'(0));
    quiet = 0;
    for (int c = 0; c < 7; c++) begin
      if (|rd_valid || |done || |gnt || mem_ren) quiet++;
      tick();
    end
    chk_int("post_rst_quiet", quiet, 0);
    eng_base[1] = 10'h020;
    eng_len[1]  = 11'd1;
    req = 3'b010;
    tick();
    chk("fresh_issue", obs(1'b1), expv(3'b010, 3'b000, 1'b1, 10'h020, 3'b000));
    tick();
    chk("fresh_drain", obs(1'b0), expv(3'b010, 3'b000, 1'b0, 10'h000, 3'b000));
    tick();
    chk("fresh_rdv", obs(1'b0), expv(3'b010, 3'b000, 1'b0, 10'h000, 3'b010));
    tick();
    chk("fresh_done", obs(1'b0), expv(3'b010, 3'b010, 1'b0, 10'h000, 3'b000));
    req = '0;
    tick();
    chk("fresh_idle", obs(1'b0), OW'(0));

    // Randomized traffic against the burst-schedule model.
    do_reset();
    for (int c = 0; c < NR + 16; c++) begin
      x_gnt[c] = '0; x_done[c] = '0; x_rdv[c] = '0; x_ren[c] = 1'b0; x_addr[c] = '0;
    end
    m_free = 0;
    m_ptr  = 0;
    for (int c = 0; c < NR; c++) begin
      chk($sformatf("rand_c%0d", c), obs(x_ren[c]),
          expv(x_gnt[c], x_done[c], x_ren[c], x_addr[c], x_rdv[c]));
      if (c % 16 == 0) begin
        checks++;
        if (rd_data !== mem_rdata) begin
          errors++;
          $display("FAIL rd_data_c%0d: got %h want %h", c, rd_data, mem_rdata);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (x_done[c][i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else begin
            eng_base[i] = ADDR_W'($urandom_range(0, 1023));
            eng_len[i]  = LEN_W'($urandom_range(0, 5));
          end
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          eng_base[i] = ADDR_W'($urandom_range(0, 1023));
          eng_len[i]  = LEN_W'($urandom_range(0, 5));
          req[i] = 1'b1;
        end
      end
      mem_rdata = {16{$urandom()}};
      if (c >= m_free && |req) begin
        w     = pick(req, m_ptr);
        oh    = NUM_REQ'(1) << w;
        len_i = int'(eng_len[w]);
        b     = eng_base[w];
        m_ptr = (w + 1) % NUM_REQ;
        if (len_i == 0) begin
          x_gnt[c+1]  = oh;
          x_done[c+1] = oh;
          m_free      = c + 2;
        end else begin
          for (int k = 1; k <= len_i + RD_LAT + 1; k++) x_gnt[c+k] = oh;
          for (int k = 1; k <= len_i; k++) begin
            x_ren[c+k]         = 1'b1;
            x_addr[c+k]        = b + ADDR_W'(k - 1);
            x_rdv[c+k+RD_LAT]  = oh;
          end
          x_done[c+len_i+RD_LAT+1] = oh;
          m_free = c + len_i + RD_LAT + 2;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
